// File: rtl/mem_sample_fetch.sv
// Read-side sequencer for the perceptron sample/label memory: walks a contiguous
// region, hides the one-cycle read latency behind a 2-entry skid FIFO and streams words.
module mem_sample_fetch #(
    parameter int unsigned N_FEAT    = 2,
    parameter int unsigned N_SAMPLES = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        mem_ena,
    output logic        wr_rd,
    output logic [10:0] addr,
    input  logic [15:0] mem_data,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned T  = N_SAMPLES * (N_FEAT + 1);
    localparam int unsigned CW = $clog2(T + 1);
    localparam int unsigned FW = $clog2(N_FEAT + 2);

    localparam logic [CW-1:0] T_CNT     = CW'(T);
    localparam logic [CW-1:0] T_LAST    = CW'(T - 1);
    localparam logic [FW-1:0] FEAT_LAST = FW'(N_FEAT);
    localparam logic [10:0]   BASE      = 11'(BASE_ADDR);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] popped_q, popped_d;
    logic [10:0]   addr_q, addr_d;
    logic [FW-1:0] feat_q, feat_d;
    logic          inflight_q, inflight_d;
    logic          inflight_last_q, inflight_last_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;
    logic [15:0]   fifo_data_q [2];
    logic          fifo_last_q [2];

    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic          done_s;
    logic [2:0]    credit_s;

    // Next-state logic: pass sequencing, read issue with credit check, FIFO bookkeeping.
    always_comb begin
        state_d         = state_q;
        issued_d        = issued_q;
        popped_d        = popped_q;
        addr_d          = addr_q;
        feat_d          = feat_q;
        inflight_last_d = inflight_last_q;
        issue_s         = 1'b0;
        done_s          = 1'b0;
        push_s          = inflight_q;
        pop_s           = (count_q != 2'd0) && out_ready;
        // A pop this cycle frees its slot before the new read can land.
        credit_s        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    issued_d = {CW{1'b0}};
                    popped_d = {CW{1'b0}};
                    addr_d   = BASE;
                    feat_d   = {FW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if ((issued_q < T_CNT) && (credit_s < 3'd2)) begin
                    issue_s         = 1'b1;
                    issued_d        = issued_q + CW'(1);
                    inflight_last_d = (feat_q == FEAT_LAST);
                    feat_d          = (feat_q == FEAT_LAST) ? {FW{1'b0}} : feat_q + FW'(1);
                    // Park on the final address instead of stepping past the region.
                    if (issued_q != T_LAST) begin
                        addr_d = addr_q + 11'd1;
                    end else begin
                        addr_d = addr_q;
                    end
                end else begin
                    issue_s = 1'b0;
                end
                if (pop_s) begin
                    popped_d = popped_q + CW'(1);
                    if (popped_q == T_LAST) begin
                        done_s  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        done_s = 1'b0;
                    end
                end else begin
                    popped_d = popped_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        inflight_d = issue_s;
        wr_ptr_d   = push_s ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop_s ? ~rd_ptr_q : rd_ptr_q;
        count_d    = count_q + {1'b0, push_s} - {1'b0, pop_s};
    end

    // Control and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            issued_q        <= {CW{1'b0}};
            popped_q        <= {CW{1'b0}};
            addr_q          <= BASE;
            feat_q          <= {FW{1'b0}};
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            state_q         <= state_d;
            issued_q        <= issued_d;
            popped_q        <= popped_d;
            addr_q          <= addr_d;
            feat_q          <= feat_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
        end
    end

    // Skid FIFO storage: captures the memory word the cycle after its read was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_data_q[0] <= 16'h0000;
            fifo_data_q[1] <= 16'h0000;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
        end else if (push_s) begin
            fifo_data_q[wr_ptr_q] <= mem_data;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = done_s;
    assign mem_ena   = issue_s;
    assign wr_rd     = 1'b0;
    assign addr      = addr_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = fifo_data_q[rd_ptr_q];
    assign out_last  = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_sample_fetch.sv
// Directed/random scoreboard bench for mem_sample_fetch: three instances cover the
// small full-rate config, a 64-sample random-stall config and the top-of-memory edge.
module tb_mem_sample_fetch;

    logic        clk;
    logic        rst;
    logic [2:0]  start_v;
    logic [2:0]  ready_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  ena_v;
    logic [2:0]  wrrd_v;
    logic [2:0]  last_v;
    logic [2:0]  valid_v;
    logic [10:0] addr_v  [3];
    logic [15:0] mdata_v [3];
    logic [15:0] odata_v [3];
    logic [15:0] mem     [1024];

    int          errors;
    int          checks;
    logic [16:0] exp_q [$];
    int          sel;
    int          cur_base;
    int          cur_t;
    int          cyc;
    int          ena_cnt;
    int          pops;
    int          done_cnt;
    int          done_first;
    int          done_last;
    bit          full_rate;
    bit          stall_prev;
    logic [15:0] prev_data;
    logic        prev_last;

    mem_sample_fetch #(.N_FEAT(2), .N_SAMPLES(4), .BASE_ADDR(0)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .mem_ena(ena_v[0]), .wr_rd(wrrd_v[0]), .addr(addr_v[0]), .mem_data(mdata_v[0]),
        .out_data(odata_v[0]), .out_last(last_v[0]), .out_valid(valid_v[0]),
        .out_ready(ready_v[0])
    );

    mem_sample_fetch #(.N_FEAT(2), .N_SAMPLES(64), .BASE_ADDR(0)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .mem_ena(ena_v[1]), .wr_rd(wrrd_v[1]), .addr(addr_v[1]), .mem_data(mdata_v[1]),
        .out_data(odata_v[1]), .out_last(last_v[1]), .out_valid(valid_v[1]),
        .out_ready(ready_v[1])
    );

    mem_sample_fetch #(.N_FEAT(2), .N_SAMPLES(2), .BASE_ADDR(1018)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .mem_ena(ena_v[2]), .wr_rd(wrrd_v[2]), .addr(addr_v[2]), .mem_data(mdata_v[2]),
        .out_data(odata_v[2]), .out_last(last_v[2]), .out_valid(valid_v[2]),
        .out_ready(ready_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read, output held when not enabled.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ena_v[k] && !wrrd_v[k]) mdata_v[k] <= mem[addr_v[k][9:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic begin_test(input int s, input int base, input int t, input bit fr);
        sel        = s;
        cur_base   = base;
        cur_t      = t;
        full_rate  = fr;
        cyc        = 0;
        ena_cnt    = 0;
        pops       = 0;
        done_cnt   = 0;
        done_first = -1;
        done_last  = -1;
        stall_prev = 1'b0;
        exp_q.delete();
    endtask

    // Expected stream for memory[i] = i starting at address 0.
    task automatic push_lin(input int n);
        for (int w = 0; w < n; w++) exp_q.push_back({((w % 3) == 2), 16'(w)});
    endtask

    task automatic chk_reset_all();
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy", busy_v[k], 0);
            chk("rst_done", done_v[k], 0);
            chk("rst_mem_ena", ena_v[k], 0);
            chk("rst_wr_rd", wrrd_v[k], 0);
            chk("rst_out_valid", valid_v[k], 0);
            chk("rst_out_data", odata_v[k], 0);
            chk("rst_out_last", last_v[k], 0);
            chk("rst_addr", addr_v[k], (k == 2) ? 1018 : 0);
        end
    endtask

    // Observe the selected instance mid-cycle and score this cycle's handshake.
    task automatic sample();
        logic [16:0] e;
        @(negedge clk);
        chk("wr_rd", wrrd_v[sel], 0);
        chk("addr_range", (32'(addr_v[sel]) <= 32'(cur_base + cur_t - 1)), 1);
        if (ena_v[sel]) begin
            chk("issue_addr", addr_v[sel], cur_base + (ena_cnt % cur_t));
            ena_cnt++;
        end
        if (stall_prev) begin
            chk("hold_valid", valid_v[sel], 1);
            chk("hold_data", odata_v[sel], prev_data);
            chk("hold_last", last_v[sel], prev_last);
        end
        if (valid_v[sel] && ready_v[sel]) begin
            chk("sb_nonempty", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", odata_v[sel], e[15:0]);
                chk("out_last", last_v[sel], e[16]);
            end
            if (full_rate) chk("word_cycle", cyc, 3 + pops);
            pops++;
        end
        if (done_v[sel]) begin
            if (done_cnt == 0) done_first = cyc;
            done_last = cyc;
            done_cnt++;
        end
        stall_prev = valid_v[sel] && !ready_v[sel];
        prev_data  = odata_v[sel];
        prev_last  = last_v[sel];
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic end_checks(input int words, input int dones);
        chk("sb_empty", exp_q.size(), 0);
        chk("word_count", pops, words);
        chk("ena_count", ena_cnt, words);
        chk("done_count", done_cnt, dones);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        start_v = 3'b000;
        ready_v = 3'b111;
        for (int i = 0; i < 1018; i++) mem[i] = 16'(i);
        mem[1018] = 16'hFE00;
        mem[1019] = 16'h0200;
        mem[1020] = 16'h0000;
        mem[1021] = 16'h0100;
        mem[1022] = 16'hFF00;
        mem[1023] = 16'hFE00;
        #1;
        chk_reset_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Full-rate pass.
        begin_test(0, 0, 12, 1'b1);
        push_lin(12);
        for (int c = 0; c < 20; c++) begin
            start_v[0] = (c == 0);
            sample();
            if (c == 1)  chk("busy_run", busy_v[0], 1);
            if (c == 1)  chk("first_ena", ena_v[0], 1);
            if (c == 15) chk("busy_after", busy_v[0], 0);
            advance();
        end
        end_checks(12, 1);
        chk("done_cycle", done_first, 14);

        // Backpressure with out_ready low in cycles 4..9.
        begin_test(0, 0, 12, 1'b0);
        push_lin(12);
        for (int c = 0; c < 30; c++) begin
            start_v[0] = (c == 0);
            ready_v[0] = !((c >= 4) && (c <= 9));
            sample();
            if ((c >= 4) && (c <= 9)) begin
                chk("stall_data", odata_v[0], 1);
                chk("stall_ena", ena_v[0], 0);
            end
            advance();
        end
        ready_v[0] = 1'b1;
        end_checks(12, 1);

        // Start re-pulsed mid-pass and on done; start after done runs a second pass.
        begin_test(0, 0, 12, 1'b0);
        push_lin(12);
        push_lin(12);
        for (int c = 0; c < 40; c++) begin
            start_v[0] = (c == 0) || (c == 5) || (c == 14) || (c == 15);
            cycle();
        end
        start_v[0] = 1'b0;
        end_checks(24, 2);
        chk("done_first", done_first, 14);
        chk("done_second", done_last, 29);

        // Asynchronous reset in cycle 7, then a fresh pass from word 0.
        begin_test(0, 0, 12, 1'b1);
        push_lin(12);
        for (int c = 0; c < 7; c++) begin
            start_v[0] = (c == 0);
            cycle();
        end
        start_v[0] = 1'b0;
        chk("pre_rst_busy", busy_v[0], 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_all();
        rst = 1'b0;
        advance();
        begin_test(0, 0, 12, 1'b1);
        push_lin(12);
        for (int c = 0; c < 20; c++) begin
            start_v[0] = (c == 0);
            cycle();
        end
        end_checks(12, 1);
        chk("rst_done_cycle", done_first, 14);

        // Random 50% stall over 64 samples.
        begin_test(1, 0, 192, 1'b0);
        push_lin(192);
        for (int c = 0; c < 1000; c++) begin
            start_v[1] = (c == 0);
            ready_v[1] = 1'($urandom_range(0, 1));
            cycle();
        end
        ready_v[1] = 1'b1;
        end_checks(192, 1);
        chk("rand_busy_end", busy_v[1], 0);

        // Top-of-memory region with signed Q6.9 values.
        begin_test(2, 1018, 6, 1'b1);
        exp_q.push_back({1'b0, 16'hFE00});
        exp_q.push_back({1'b0, 16'h0200});
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b0, 16'h0100});
        exp_q.push_back({1'b0, 16'hFF00});
        exp_q.push_back({1'b1, 16'hFE00});
        for (int c = 0; c < 14; c++) begin
            start_v[2] = (c == 0);
            cycle();
        end
        end_checks(6, 1);
        chk("edge_done_cycle", done_first, 8);
        chk("edge_addr_hold", addr_v[2], 1023);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
